pb_conditioner: RTL
===================

// Module: pb_conditioner
// PURPOSE
//   Front-end stage for the push-button bus: turns the 15 raw, asynchronous button pins into
//   clean, debounced levels and one-cycle press strobes before they reach the synth core.
//   Also priority-encodes the 13 note keys, and keeps the octave and the play-mode state.
//   Sits between the breakout-board pins and top_asic; all outputs are registered, glitch-free.
// PARAMETERS
//   NUM_PB        15   number of button inputs; pb[NUM_PB-1] is MODE, pb[NUM_PB-2] is OCTAVE,
//                      all lower bits are note keys
//   TICK_DIV      1000 clk cycles per debounce sample tick (>=2)
//   STABLE_TICKS  10   consecutive ticks of disagreement required to accept a new level (>=1)
// PORTS
//   clk         in   1       system clock
//   reset       in   1       asynchronous, active-high reset
//   pb          in   NUM_PB  raw buttons, asynchronous, active-high (pressed = 1)
//   keys_db     out  NUM_PB  debounced button levels
//   keys_rise   out  NUM_PB  one-cycle strobe on each debounced 0->1 transition
//   note_idx    out  4       lowest-index pressed note key (0..NUM_PB-3)
//   note_valid  out  1       at least one note key pressed
//   octave      out  2       octave select, 0..3
//   mode        out  2       play mode, 0..3
// BEHAVIOUR
//   - reset (async, any time, incl. mid-debounce): all flops to 0 at once; all outputs 0;
//     tick divider, debounce counters and sync stages all 0. First tick is TICK_DIV cycles after release.
//   - sync: pb goes through a 2-flop synchroniser per bit -> pb_s; nothing else samples pb.
//   - tick: free-running divider counts 0..TICK_DIV-1 and wraps; tick=1 for one cycle at TICK_DIV-1.
//   - debounce, per bit i, only on tick cycles:
//       pb_s[i]==keys_db[i]             -> cnt[i]<=0
//       else if cnt[i]==STABLE_TICKS-1  -> keys_db[i]<=pb_s[i], cnt[i]<=0
//       else                            -> cnt[i]<=cnt[i]+1
//     Any agreeing sample restarts the count. cnt width is clog2(STABLE_TICKS); no overflow.
//   - keys_rise[i] = keys_db[i] & ~keys_db_q[i] (registered): high exactly 1 cycle, the cycle after keys_db rises.
//     Falling edges produce no strobe.
//   - note encode (registered, 1 cycle after keys_db): note_valid = |keys_db[NUM_PB-3:0];
//     note_idx = lowest set index. Simultaneous keys: lowest wins. No key: note_idx holds its last value, note_valid=0.
//   - octave: +1 on keys_rise[NUM_PB-2], wraps 3->0. mode: +1 on keys_rise[NUM_PB-1], wraps 3->0.
//     Both update the cycle after the strobe. The two counters are independent: same-cycle strobes both apply.
//   - Holding a button gives no auto-repeat. Release then press again is needed for the next strobe.
//   - Press latency from the pb edge to keys_db: 2 sync cycles + up to STABLE_TICKS ticks, in
//     [2+(STABLE_TICKS-1)*TICK_DIV+1, 2+STABLE_TICKS*TICK_DIV+1] cycles.
//     Release has the same latency.
// TESTING (bench params TICK_DIV=4, STABLE_TICKS=3, NUM_PB=15)
//   1 reset held 5 cycles with pb=15'h7FFF -> every output 0 during reset and the cycle after release.
//   2 pb[5] 0->1 and held -> keys_db[5] rises 11..15 cycles later.
//     keys_rise[5] is high 1 cycle, then note_valid=1 and note_idx=5.
//     Release pb[5] -> keys_db[5]=0 after 11..15 cycles, note_valid=0, no strobe.
//   3 pb[5] high for 6 cycles then low (glitch) -> keys_db, keys_rise, note_valid never change.
//   4 pb[3] and pb[9] pressed together -> note_idx=3.
//     Release pb[3] -> note_idx=9.
//   5 press/release pb[14] five times -> mode steps 1,2,3,0,1.
//     Press pb[13] in the same cycle as the fifth pb[14] press -> octave=1 and mode=1 land on the same cycle.
//   6 assert reset while cnt[7] is mid-count with pb[7] held, then release -> keys_db[7]=0.
//     pb[7] is re-accepted only after a full 11..15 cycle window.

Source files
------------

// File: rtl/pb_conditioner.sv
// Push-button front end: synchronises, debounces and edge-detects the raw button pins,
// priority-encodes the note keys and keeps the octave / play-mode counters.
module pb_conditioner #(
    parameter int NUM_PB       = 15,
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_TICKS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_PB-1:0] pb,
    output logic [NUM_PB-1:0] keys_db,
    output logic [NUM_PB-1:0] keys_rise,
    output logic [3:0]        note_idx,
    output logic              note_valid,
    output logic [1:0]        octave,
    output logic [1:0]        mode
);

    localparam int NUM_NOTES = NUM_PB - 2;
    localparam int DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W     = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [NUM_PB-1:0] pb_m;
    logic [NUM_PB-1:0] pb_s;
    logic [DIV_W-1:0]  div;
    logic              tick;
    logic [CNT_W-1:0]  cnt [NUM_PB];
    logic [NUM_PB-1:0] keys_db_q;
    logic [3:0]        lowest_idx;
    logic              any_note;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pb_m <= '0;
            pb_s <= '0;
        end else begin
            pb_m <= pb;
            pb_s <= pb_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign tick = (div == DIV_LAST);

    // NOTE: the counter array is a small flop bank, so it is cleared by reset like any other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keys_db <= '0;
            for (int i = 0; i < NUM_PB; i++) cnt[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < NUM_PB; i++) begin
                if (pb_s[i] == keys_db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    keys_db[i] <= pb_s[i];
                    cnt[i]     <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keys_db_q <= '0;
            keys_rise <= '0;
        end else begin
            keys_db_q <= keys_db;
            keys_rise <= keys_db & ~keys_db_q;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred; the
    // descending scan lets the lowest pressed key overwrite higher ones.
    always_comb begin
        lowest_idx = '0;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (keys_db[i]) lowest_idx = 4'(i);
        end
    end

    assign any_note = |keys_db[NUM_NOTES-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note_idx   <= '0;
            note_valid <= 1'b0;
        end else begin
            note_valid <= any_note;
            if (any_note) note_idx <= lowest_idx;
        end
    end

    // Two-bit counters wrap 3->0 naturally; the two strobes are independent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            octave <= '0;
            mode   <= '0;
        end else begin
            if (keys_rise[NUM_PB-2]) octave <= octave + 2'd1;
            if (keys_rise[NUM_PB-1]) mode   <= mode + 2'd1;
        end
    end

endmodule
